// File: rtl/sdram_port_arbiter.sv
// Two-client round-robin arbiter for the single SDRAM wrapper word port.
// Optional WAIT timeout abort is enabled with `define ARB_TIMEOUT_EN.
module sdram_port_arbiter #(
  parameter int ADDR_W  = 26,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_c0_req,
  input  logic              i_c0_write,
  input  logic [ADDR_W-1:0] i_c0_addr,
  input  logic [DATA_W-1:0] i_c0_wdata,
  output logic              o_c0_ack,
  output logic [DATA_W-1:0] o_c0_rdata,
  output logic              o_c0_err,
  input  logic              i_c1_req,
  input  logic              i_c1_write,
  input  logic [ADDR_W-1:0] i_c1_addr,
  input  logic [DATA_W-1:0] i_c1_wdata,
  output logic              o_c1_ack,
  output logic [DATA_W-1:0] o_c1_rdata,
  output logic              o_c1_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_write,
  output logic              o_mem_read,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_done,
  output logic              o_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic              last_id, gid, wr;
  logic              gnt_valid, gnt_id, sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              done_ev, timeout_hit, finish;

  // A done pulse always wins over a timeout landing in the same cycle.
  assign done_ev = (state == WAIT) && i_mem_done;
  assign finish  = done_ev || timeout_hit;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    state_nxt = state;
    if (i_c0_req && i_c1_req) begin
      gnt_valid = 1'b1;
      gnt_id    = ~last_id;
    end else if (i_c0_req) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b0;
    end else if (i_c1_req) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b1;
    end
    sel_write = gnt_id ? i_c1_write : i_c0_write;
    sel_addr  = gnt_id ? i_c1_addr  : i_c0_addr;
    sel_wdata = gnt_id ? i_c1_wdata : i_c0_wdata;
    case (state)
      IDLE:    if (gnt_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (finish) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      last_id     <= 1'b1;
      gid         <= 1'b0;
      wr          <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_write <= 1'b0;
      o_mem_read  <= 1'b0;
      o_c0_ack    <= 1'b0;
      o_c1_ack    <= 1'b0;
      o_c0_rdata  <= '0;
      o_c1_rdata  <= '0;
      o_busy      <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_busy      <= (state_nxt != IDLE);
      o_mem_write <= 1'b0;
      o_mem_read  <= 1'b0;
      o_c0_ack    <= 1'b0;
      o_c1_ack    <= 1'b0;
      if (state == IDLE && gnt_valid) begin
        gid         <= gnt_id;
        wr          <= sel_write;
        o_mem_addr  <= sel_addr;
        o_mem_wdata <= sel_wdata;
        o_mem_write <= sel_write;
        o_mem_read  <= ~sel_write;
      end
      // Writes and aborted reads return zero data.
      if (finish) begin
        if (gid) begin
          o_c1_ack   <= 1'b1;
          o_c1_rdata <= (wr || timeout_hit) ? '0 : i_mem_rdata;
        end else begin
          o_c0_ack   <= 1'b1;
          o_c0_rdata <= (wr || timeout_hit) ? '0 : i_mem_rdata;
        end
      end
      if (state == RESP) last_id <= gid;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Abort on the WAIT cycle whose increment would reach TIMEOUT.
  assign timeout_hit = (state == WAIT) && !i_mem_done &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wait_cnt <= '0;
      o_c0_err <= 1'b0;
      o_c1_err <= 1'b0;
    end else begin
      if (state == ISSUE)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (finish) begin
        if (gid) o_c1_err <= timeout_hit;
        else     o_c0_err <= timeout_hit;
      end else if (state == RESP) begin
        if (gid) o_c1_err <= 1'b0;
        else     o_c0_err <= 1'b0;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign o_c0_err    = 1'b0;
  assign o_c1_err    = 1'b0;
`endif

endmodule
